// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if: bus bundle for the reg_file_sb register file.
//   master : decode side, drives read addresses, write, mark and flush strobes
//   slave  : register file, returns read data, per-port busy and busy_vec
// Parameters must match those of the reg_file_sb instance it connects to.
interface reg_file_sb_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  localparam int NREGS = 2 ** ADDR_W;

  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              rd_busy1;
  logic              rd_busy2;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              mark_en;
  logic [ADDR_W-1:0] mark_addr;
  logic              flush;
  logic [NREGS-1:0]  busy_vec;

  modport master (
    output rd_addr1, rd_addr2,
    output wr_en, wr_addr, wr_data,
    output mark_en, mark_addr, flush,
    input  rd_data1, rd_data2, rd_busy1, rd_busy2, busy_vec
  );

  modport slave (
    input  rd_addr1, rd_addr2,
    input  wr_en, wr_addr, wr_data,
    input  mark_en, mark_addr, flush,
    output rd_data1, rd_data2, rd_busy1, rd_busy2, busy_vec
  );
endinterface

// File: rtl/reg_file_sb.sv
// reg_file_sb: two-read / one-write register file with optional write-through
// bypass, optional hardwired zero register and a per-register pending-write
// (busy) scoreboard used by decode for hazard detection.
// Ports:
//   clk    : clock, all state updates on posedge
//   rst_n  : asynchronous active-low reset, clears data and busy bits
//   bus    : reg_file_sb_if.slave
//            rd_addr1/2 -> rd_data1/2, rd_busy1/2 (combinational)
//            wr_en/wr_addr/wr_data : write, clears busy of the target
//            mark_en/mark_addr     : set busy of the target (next cycle)
//            flush                 : clear every busy bit
//            busy_vec              : registered busy bits of all registers
module reg_file_sb #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  reg_file_sb_if.slave  bus
);
  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  busy_q;
  logic [NREGS-1:0]  busy_d;

  logic              wr_ok;
  logic              mark_ok;
  logic              fwd_en;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              rd_busy1;
  logic              rd_busy2;

  // Writes and marks aimed at the hardwired zero register are dropped.
  assign wr_ok   = bus.wr_en   && !(ZERO_REG && (bus.wr_addr   == '0));
  assign mark_ok = bus.mark_en && !(ZERO_REG && (bus.mark_addr == '0));

  // Forwarding is suppressed during reset so reads return 0 for every
  // address while rst_n is low, even with a write strobe present.
  assign fwd_en = BYPASS && wr_ok && rst_n;

  always_comb begin
    regs_d = regs_q;
    if (wr_ok) begin
      regs_d[bus.wr_addr] = bus.wr_data;
    end
  end

  // Priority: flush over mark over write-clear. A mark and a write to the
  // same index leave busy set, since the mark names a newer producer.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok) begin
      busy_d[bus.wr_addr] = 1'b0;
    end
    if (bus.flush) begin
      busy_d = '0;
    end else if (mark_ok) begin
      busy_d[bus.mark_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    rd_data1 = regs_q[bus.rd_addr1];
    rd_busy1 = busy_q[bus.rd_addr1];
    if (ZERO_REG && (bus.rd_addr1 == '0)) begin
      rd_data1 = '0;
      rd_busy1 = 1'b0;
    end else if (fwd_en && (bus.wr_addr == bus.rd_addr1)) begin
      // The forwarded value is the one the pending producer was waiting on,
      // so the reader no longer has to stall.
      rd_data1 = bus.wr_data;
      rd_busy1 = 1'b0;
    end
  end

  always_comb begin
    rd_data2 = regs_q[bus.rd_addr2];
    rd_busy2 = busy_q[bus.rd_addr2];
    if (ZERO_REG && (bus.rd_addr2 == '0)) begin
      rd_data2 = '0;
      rd_busy2 = 1'b0;
    end else if (fwd_en && (bus.wr_addr == bus.rd_addr2)) begin
      rd_data2 = bus.wr_data;
      rd_busy2 = 1'b0;
    end
  end

  assign bus.rd_data1 = rd_data1;
  assign bus.rd_data2 = rd_data2;
  assign bus.rd_busy1 = rd_busy1;
  assign bus.rd_busy2 = rd_busy2;
  assign bus.busy_vec = busy_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Testbench for reg_file_sb: two 16x16 instances (bypass on / off) share one
// stimulus stream and one storage/scoreboard model; a 32x32 instance is swept.
module tb_reg_file_sb;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  reg_file_sb_if #(.DATA_W(16), .ADDR_W(4)) if_a ();
  reg_file_sb_if #(.DATA_W(16), .ADDR_W(4)) if_b ();
  reg_file_sb_if #(.DATA_W(32), .ADDR_W(5)) if_c ();

  reg_file_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1'b1), .BYPASS(1'b1))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
  reg_file_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1'b1), .BYPASS(1'b0))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));
  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c.slave));

  assign if_b.rd_addr1  = if_a.rd_addr1;
  assign if_b.rd_addr2  = if_a.rd_addr2;
  assign if_b.wr_en     = if_a.wr_en;
  assign if_b.wr_addr   = if_a.wr_addr;
  assign if_b.wr_data   = if_a.wr_data;
  assign if_b.mark_en   = if_a.mark_en;
  assign if_b.mark_addr = if_a.mark_addr;
  assign if_b.flush     = if_a.flush;

  int n_cmp = 0;
  int n_mis = 0;

  // Architectural model: register contents and busy bits.
  logic [15:0] mdl_mem [16];
  logic [15:0] mdl_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mdl_clear();
    for (int i = 0; i < 16; i++) mdl_mem[i] = 16'h0000;
    mdl_busy = 16'h0000;
  endtask

  // Effect of one posedge given the inputs currently presented.
  task automatic mdl_update();
    logic [15:0] nb;
    if (!rst_n) begin
      mdl_clear();
    end else begin
      nb = mdl_busy;
      if (if_a.wr_en && if_a.wr_addr != 4'd0) begin
        mdl_mem[if_a.wr_addr] = if_a.wr_data;
        nb[if_a.wr_addr] = 1'b0;
      end
      if (if_a.flush) nb = 16'h0000;
      else if (if_a.mark_en && if_a.mark_addr != 4'd0) nb[if_a.mark_addr] = 1'b1;
      mdl_busy = nb;
    end
  endtask

  function automatic logic [15:0] exp_data(input bit byp, input logic [3:0] a);
    if (a == 4'd0) return 16'h0000;
    if (byp && if_a.wr_en && if_a.wr_addr == a) return if_a.wr_data;
    return mdl_mem[a];
  endfunction

  function automatic logic exp_busy(input bit byp, input logic [3:0] a);
    if (a == 4'd0) return 1'b0;
    if (byp && if_a.wr_en && if_a.wr_addr == a) return 1'b0;
    return mdl_busy[a];
  endfunction

  task automatic check_ab(input string tag);
    chk({tag, ".a.d1"}, 32'(if_a.rd_data1), 32'(exp_data(1'b1, if_a.rd_addr1)));
    chk({tag, ".a.d2"}, 32'(if_a.rd_data2), 32'(exp_data(1'b1, if_a.rd_addr2)));
    chk({tag, ".a.b1"}, 32'(if_a.rd_busy1), 32'(exp_busy(1'b1, if_a.rd_addr1)));
    chk({tag, ".a.b2"}, 32'(if_a.rd_busy2), 32'(exp_busy(1'b1, if_a.rd_addr2)));
    chk({tag, ".a.bv"}, 32'(if_a.busy_vec), 32'(mdl_busy));
    chk({tag, ".b.d1"}, 32'(if_b.rd_data1), 32'(exp_data(1'b0, if_a.rd_addr1)));
    chk({tag, ".b.d2"}, 32'(if_b.rd_data2), 32'(exp_data(1'b0, if_a.rd_addr2)));
    chk({tag, ".b.b1"}, 32'(if_b.rd_busy1), 32'(exp_busy(1'b0, if_a.rd_addr1)));
    chk({tag, ".b.b2"}, 32'(if_b.rd_busy2), 32'(exp_busy(1'b0, if_a.rd_addr2)));
    chk({tag, ".b.bv"}, 32'(if_b.busy_vec), 32'(mdl_busy));
  endtask

  task automatic drive(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                       input logic me, input logic [3:0] ma, input logic fl,
                       input logic [3:0] r1, input logic [3:0] r2);
    if_a.wr_en = we;  if_a.wr_addr = wa;  if_a.wr_data = wd;
    if_a.mark_en = me; if_a.mark_addr = ma; if_a.flush = fl;
    if_a.rd_addr1 = r1; if_a.rd_addr2 = r2;
  endtask

  // Inputs are presented just after a posedge; outputs are checked on the
  // negedge; the model advances on the following posedge.
  task automatic cycle(input string tag);
    @(negedge clk);
    check_ab(tag);
    @(posedge clk);
    mdl_update();
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    mdl_clear();
    drive(1'b1, 4'd3, 16'hFFFF, 1'b1, 4'd4, 1'b0, 4'd3, 4'd3);
    if_c.wr_en = 1'b0; if_c.wr_addr = '0; if_c.wr_data = '0;
    if_c.mark_en = 1'b0; if_c.mark_addr = '0; if_c.flush = 1'b0;
    if_c.rd_addr1 = '0; if_c.rd_addr2 = '0;

    // In reset: everything reads zero, even with a live write strobe.
    #2;
    chk("rst0.a.d1", 32'(if_a.rd_data1), 32'h0);
    chk("rst0.a.b1", 32'(if_a.rd_busy1), 32'h0);
    chk("rst0.a.bv", 32'(if_a.busy_vec), 32'h0);
    chk("rst0.b.d1", 32'(if_b.rd_data1), 32'h0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b0, 4'd3, 4'd4);
    @(posedge clk); mdl_update(); #1;
    cycle("post_rst");

    // Reset mid-cycle clears storage and busy without a clock edge.
    drive(1'b1, 4'd3, 16'hA5A5, 1'b1, 4'd4, 1'b0, 4'd3, 4'd4);
    cycle("rst_wr");
    drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b0, 4'd3, 4'd4);
    @(negedge clk);
    chk("rst_pre.d1", 32'(if_a.rd_data1), 32'hA5A5);
    chk("rst_pre.b2", 32'(if_a.rd_busy2), 32'h1);
    #1;
    rst_n = 1'b0;
    mdl_clear();
    #1;
    chk("rst_mid.a.d1", 32'(if_a.rd_data1), 32'h0);
    chk("rst_mid.a.bv", 32'(if_a.busy_vec), 32'h0);
    chk("rst_mid.a.b2", 32'(if_a.rd_busy2), 32'h0);
    chk("rst_mid.b.d1", 32'(if_b.rd_data1), 32'h0);
    // A write held across a posedge in reset is lost.
    drive(1'b1, 4'd6, 16'hBEEF, 1'b1, 4'd6, 1'b0, 4'd6, 4'd3);
    #1;
    chk("rst_mid.nofwd", 32'(if_a.rd_data1), 32'h0);
    @(posedge clk); mdl_update();
    #2;
    rst_n = 1'b1;
    drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b0, 4'd6, 4'd3);
    cycle("rst_lost");

    // Bypass on r5.
    drive(1'b1, 4'd5, 16'h1234, 1'b0, 4'd0, 1'b0, 4'd5, 4'd5);
    @(negedge clk);
    chk("byp.a.d1", 32'(if_a.rd_data1), 32'h1234);
    chk("byp.a.d2", 32'(if_a.rd_data2), 32'h1234);
    chk("byp.b.d1", 32'(if_b.rd_data1), 32'h0);
    @(posedge clk); mdl_update(); #1;
    drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b0, 4'd5, 4'd5);
    @(negedge clk);
    chk("byp_next.a.d1", 32'(if_a.rd_data1), 32'h1234);
    chk("byp_next.b.d2", 32'(if_b.rd_data2), 32'h1234);
    @(posedge clk); mdl_update(); #1;

    // Zero register.
    drive(1'b1, 4'd0, 16'hFFFF, 1'b1, 4'd0, 1'b0, 4'd0, 4'd0);
    cycle("zero_wr");
    drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd5);
    @(negedge clk);
    chk("zero.d1", 32'(if_a.rd_data1), 32'h0);
    chk("zero.b1", 32'(if_a.rd_busy1), 32'h0);
    chk("zero.bv0", 32'(if_a.busy_vec[0]), 32'h0);
    @(posedge clk); mdl_update(); #1;

    // Scoreboard on r7.
    drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd7, 1'b0, 4'd7, 4'd5);
    @(negedge clk);
    chk("sb_c0.b1", 32'(if_a.rd_busy1), 32'h0);
    check_ab("sb_c0");
    @(posedge clk); mdl_update(); #1;
    drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b0, 4'd7, 4'd5);
    @(negedge clk);
    chk("sb_c1.b1", 32'(if_a.rd_busy1), 32'h1);
    @(posedge clk); mdl_update(); #1;
    cycle("sb_c2");
    drive(1'b1, 4'd7, 16'h0042, 1'b0, 4'd0, 1'b0, 4'd7, 4'd7);
    @(negedge clk);
    chk("sb_c3.b1", 32'(if_a.rd_busy1), 32'h0);
    chk("sb_c3.d1", 32'(if_a.rd_data1), 32'h0042);
    chk("sb_c3.nobyp.b1", 32'(if_b.rd_busy1), 32'h1);
    @(posedge clk); mdl_update(); #1;
    drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b0, 4'd7, 4'd7);
    @(negedge clk);
    chk("sb_c4.bv7", 32'(if_a.busy_vec[7]), 32'h0);
    @(posedge clk); mdl_update(); #1;

    // Conflicts on r9.
    drive(1'b1, 4'd9, 16'h0BEE, 1'b1, 4'd9, 1'b0, 4'd9, 4'd10);
    cycle("conf_mw");
    drive(1'b1, 4'd10, 16'h0077, 1'b1, 4'd9, 1'b1, 4'd9, 4'd10);
    @(negedge clk);
    chk("conf.d9", 32'(if_a.rd_data1), 32'h0BEE);
    chk("conf.bv9", 32'(if_a.busy_vec[9]), 32'h1);
    check_ab("conf_fl");
    @(posedge clk); mdl_update(); #1;
    drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b0, 4'd9, 4'd10);
    @(negedge clk);
    chk("flush.bv", 32'(if_a.busy_vec), 32'h0);
    chk("flush.d10", 32'(if_a.rd_data2), 32'h0077);
    @(posedge clk); mdl_update(); #1;

    // Randomised traffic against the model.
    for (int n = 0; n < 300; n++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom), 16'($urandom),
            1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 15) == 0),
            4'($urandom), 4'($urandom));
      if ($urandom_range(0, 3) == 0) if_a.rd_addr2 = if_a.wr_addr;
      cycle("rnd");
    end
    drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0);

    // 32x32 sweep.
    for (int i = 0; i < 32; i++) begin
      if_c.wr_en   = 1'b1;
      if_c.wr_addr = 5'(i);
      if_c.wr_data = (i == 0) ? 32'hFFFF_FFFF : 32'(i) * 32'h0101_0101;
      @(posedge clk); #1;
    end
    if_c.wr_en = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if_c.rd_addr1 = 5'(i);
      if_c.rd_addr2 = 5'(31 - i);
      #2;
      chk("sweep.d1", if_c.rd_data1, (i == 0) ? 32'h0 : 32'(i) * 32'h0101_0101);
      chk("sweep.d2", if_c.rd_data2, (i == 31) ? 32'h0 : 32'(31 - i) * 32'h0101_0101);
    end
    chk("sweep.bv", if_c.busy_vec, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised register file with write-through bypass, hardwired zero register and a per-register pending-write scoreboard. It replaces the fixed 16x16 tri-state bitline register file in the decode stage. Read data are driven as plain outputs, not tri-state bitlines. Decode uses the busy flags to detect load-use and multi-cycle-producer hazards without a separate scoreboard block.

## Interface
Parameters:
- DATA_W, 16, register width in bits
- ADDR_W, 4, register index width; register count NREGS = 2**ADDR_W
- ZERO_REG, 1, when 1 register 0 always reads 0, ignores writes and is never busy
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  reset; asynchronous, active-low
- rd_addr1  in  ADDR_W  read port 1 index
- rd_addr2  in  ADDR_W  read port 2 index
- rd_data1  out  DATA_W  read port 1 data, combinational
- rd_data2  out  DATA_W  read port 2 data, combinational
- rd_busy1  out  1  pending write outstanding on rd_addr1
- rd_busy2  out  1  pending write outstanding on rd_addr2
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write index
- wr_data  in  DATA_W  write data
- mark_en  in  1  mark a register as having a pending producer
- mark_addr  in  ADDR_W  index to mark busy
- flush  in  1  clear all busy bits; register contents are unaffected
- busy_vec  out  NREGS  current busy bit of every register, registered

## Operation
- Storage: NREGS x DATA_W flops, array regs[]. Scoreboard: NREGS flops, array busy[].
- Write: on posedge, if wr_en and the zero-register rule does not block it, regs[wr_addr] <= wr_data and busy[wr_addr] <= 0.
- Zero-register rule: with ZERO_REG=1, writes and marks to index 0 are ignored, regs[0] reads 0 and busy[0] stays 0.
- Mark: on posedge, if mark_en and the zero-register rule does not block it, busy[mark_addr] <= 1.
- Same-cycle conflicts (priority, highest first): flush, then mark, then write-clear.
  - flush=1 clears every busy bit. A mark issued in the same cycle is dropped. The data write still happens.
  - mark_addr==wr_addr with both strobes set: the data is written and busy ends at 1, because a newer producer is now pending.
- Read, per port n: rd_data_n = regs[rd_addr_n], except:
  - ZERO_REG=1 and rd_addr_n==0: rd_data_n = 0.
  - BYPASS=1, wr_en=1, wr_addr==rd_addr_n, and the write is not blocked by the zero-register rule: rd_data_n = wr_data.
- Busy read, per port n: rd_busy_n = busy[rd_addr_n], except it is 0 when a bypassing write to that index is active in the same cycle. It is forced to 0 even if busy is 1.
- Busy read with BYPASS=0: rd_busy_n = busy[rd_addr_n] with no forcing. Write data become visible only the cycle after the write.
- Both read ports are fully independent. Identical addresses on both ports are legal and return identical values.

## Timing
- Reset: asserting rst_n=0 immediately clears all regs[] and busy[], regardless of clk.
  - While in reset: busy_vec=0, rd_busy1/2=0, and rd_data1/2=0 for every address.
- Reset deassertion is synchronised externally. The first write is accepted on the first posedge with rst_n=1.
- Reset mid-operation: any write or mark presented in the same cycle is lost. No partial update is allowed.
- Read latency: 0 cycles, combinational from rd_addr_n, regs[] and the write port.
- Write latency: data are visible through storage 1 cycle after the write posedge. With BYPASS=1 they are also visible in the same cycle.
- Mark latency: busy_vec and rd_busy_n rise 1 cycle after the mark posedge. A mark is not bypassed.
- Decode must tolerate this: an instruction reading the index in the mark cycle sees busy=0.
- No handshakes. Every strobe is single-cycle and accepted unconditionally.

## Test plan
- Reset: write 0xA5A5 to r3, then pulse rst_n low mid-cycle -> rd_data1 with rd_addr1=3 reads 0x0000 immediately, and busy_vec=0 with no clock edge.
- Bypass: wr_en=1, wr_addr=5, wr_data=0x1234, rd_addr1=rd_addr2=5 in the same cycle -> both rd_data read 0x1234 that cycle and 0x1234 the next cycle with wr_en=0. With BYPASS=0 the first cycle reads the old value.
- Zero register: write 0xFFFF to r0 and mark r0 -> rd_data1 reads 0x0000, rd_busy1=0, busy_vec[0]=0.
- Scoreboard: mark r7 in cycle 0 -> rd_busy1 (rd_addr1=7) is 0 in cycle 0 and 1 in cycle 1.
  - Write r7=0x0042 in cycle 3 -> rd_busy1=0 and rd_data1=0x0042 in cycle 3, busy_vec[7]=0 in cycle 4.
- Conflicts, all on r9:
  - mark r9 and write r9=0x0BEE in the same cycle -> next cycle r9 holds 0x0BEE and busy_vec[9]=1.
  - Then flush together with mark r9 -> busy_vec=0 next cycle.
- Sweep: DATA_W=32, ADDR_W=5 -> write index i with value i*0x01010101 for all 32 registers, then read all 32 on both ports -> every value matches, r0=0.
